// File: rtl/mem_port_arbiter.sv
// Arbitrates one req/ack memory bus between the instruction-fetch and data ports,
// giving data priority, with an optional watchdog that aborts unanswered requests.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clock__i,
    input  logic                  reset__i,
    input  logic                  iReq__i,
    input  logic [ADDR_WIDTH-1:0] iAddr__i,
    output logic [DATA_WIDTH-1:0] iData__o,
    output logic                  iReady__o,
    input  logic                  dRead__i,
    input  logic                  dWrite__i,
    input  logic [ADDR_WIDTH-1:0] dAddr__i,
    input  logic [DATA_WIDTH-1:0] dWData__i,
    output logic [DATA_WIDTH-1:0] dRData__o,
    output logic                  dReady__o,
    output logic                  stall__o,
    output logic                  memReq__o,
    output logic                  memWe__o,
    output logic [ADDR_WIDTH-1:0] memAddr__o,
    output logic [DATA_WIDTH-1:0] memWData__o,
    input  logic                  memAck__i,
    input  logic [DATA_WIDTH-1:0] memRData__i,
    output logic                  error__o
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TLIMIT = CW'(TIMEOUT);
    localparam bit WDOG_ON = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        IDLE,
        IBUSY,
        DBUSY
    } state_e;

    state_e                state_q, state_d;
    logic                  memReq_q, memReq_d;
    logic                  memWe_q, memWe_d;
    logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
    logic [DATA_WIDTH-1:0] memWData_q, memWData_d;
    logic [DATA_WIDTH-1:0] iData_q, iData_d;
    logic [DATA_WIDTH-1:0] dRData_q, dRData_d;
    logic                  iReady_q, iReady_d;
    logic                  dReady_q, dReady_d;
    logic                  error_q, error_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic                  dPend;
    logic                  iPend;
    logic [CW-1:0]         cntInc;
    logic                  timedOut;
    logic                  finish;

    always_ff @(posedge clock__i) begin
        if (reset__i) begin
            state_q    <= IDLE;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWData_q <= '0;
            iData_q    <= '0;
            dRData_q   <= '0;
            iReady_q   <= 1'b0;
            dReady_q   <= 1'b0;
            error_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            memReq_q   <= memReq_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWData_q <= memWData_d;
            iData_q    <= iData_d;
            dRData_q   <= dRData_d;
            iReady_q   <= iReady_d;
            dReady_q   <= dReady_d;
            error_q    <= error_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        memReq_d   = memReq_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memWData_d = memWData_q;
        iData_d    = iData_q;
        dRData_d   = dRData_q;
        iReady_d   = 1'b0;
        dReady_d   = 1'b0;
        error_d    = error_q;
        cnt_d      = cnt_q;

        // A port whose ready is pulsing this cycle is not pending, so a held request is not re-granted.
        dPend    = (dRead__i | dWrite__i) & ~dReady_q;
        iPend    = iReq__i & ~iReady_q;
        cntInc   = cnt_q + CW'(1);
        timedOut = WDOG_ON && (cntInc == TLIMIT);
        finish   = memAck__i | timedOut;

        case (state_q)
            IDLE: begin
                if (dPend) begin
                    state_d   = DBUSY;
                    memReq_d  = 1'b1;
                    memWe_d   = dWrite__i;
                    memAddr_d = dAddr__i;
                    cnt_d     = '0;
                    if (dWrite__i) begin
                        memWData_d = dWData__i;
                    end
                end else if (iPend) begin
                    state_d   = IBUSY;
                    memReq_d  = 1'b1;
                    memWe_d   = 1'b0;
                    memAddr_d = iAddr__i;
                    cnt_d     = '0;
                end
            end
            IBUSY, DBUSY: begin
                if (finish) begin
                    state_d  = IDLE;
                    memReq_d = 1'b0;
                    cnt_d    = '0;
                    // An ack arriving together with the timeout completes normally.
                    if (!memAck__i) begin
                        error_d = 1'b1;
                    end
                    if (state_q == IBUSY) begin
                        iReady_d = 1'b1;
                        iData_d  = memAck__i ? memRData__i : '1;
                    end else begin
                        dReady_d = 1'b1;
                        if (!memAck__i) begin
                            dRData_d = '1;
                        end else if (!memWe_q) begin
                            dRData_d = memRData__i;
                        end
                    end
                end else begin
                    cnt_d = cntInc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign stall__o    = (iReq__i & ~iReady_q) | ((dRead__i | dWrite__i) & ~dReady_q);
    assign memReq__o   = memReq_q;
    assign memWe__o    = memWe_q;
    assign memAddr__o  = memAddr_q;
    assign memWData__o = memWData_q;
    assign iData__o    = iData_q;
    assign dRData__o   = dRData_q;
    assign iReady__o   = iReady_q;
    assign dReady__o   = dReady_q;
    assign error__o    = error_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a transaction-level model is compared
// every cycle, plus hand-computed literal checks per directed scenario.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          iReq, dRead, dWrite, memAck;
    logic [AW-1:0] iAddr, dAddr;
    logic [DW-1:0] dWData, memRData;
    logic [DW-1:0] iData, dRData, memWData;
    logic [AW-1:0] memAddr;
    logic          iReady, dReady, stall, memReq, memWe, errorFlag;

    int  passCount  = 0;
    int  checkCount = 0;
    bit  checkEn    = 1'b0;
    int  cyc        = 0;
    int  reqRun     = 0;
    int  lastReqLen = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .clock__i   (clk),
        .reset__i   (reset),
        .iReq__i    (iReq),
        .iAddr__i   (iAddr),
        .iData__o   (iData),
        .iReady__o  (iReady),
        .dRead__i   (dRead),
        .dWrite__i  (dWrite),
        .dAddr__i   (dAddr),
        .dWData__i  (dWData),
        .dRData__o  (dRData),
        .dReady__o  (dReady),
        .stall__o   (stall),
        .memReq__o  (memReq),
        .memWe__o   (memWe),
        .memAddr__o (memAddr),
        .memWData__o(memWData),
        .memAck__i  (memAck),
        .memRData__i(memRData),
        .error__o   (errorFlag)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: which port owns the bus, and how long its request has been up.
    int            mOwner;
    int            mAge;
    bit            mReq, mWe, mIReady, mDReady, mErr;
    logic [AW-1:0] mAddr;
    logic [DW-1:0] mWData, mIData, mDRData;
    bit            dWants, iWants, aborted;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            mOwner = 0; mAge = 0; mReq = 0; mWe = 0; mIReady = 0; mDReady = 0; mErr = 0;
            mAddr = '0; mWData = '0; mIData = '0; mDRData = '0;
        end else begin
            dWants  = (dRead || dWrite) && !mDReady;
            iWants  = iReq && !mIReady;
            mIReady = 0;
            mDReady = 0;
            if (mOwner == 0) begin
                if (dWants) begin
                    mOwner = 2; mAge = 0; mReq = 1; mWe = dWrite; mAddr = dAddr;
                    if (dWrite) mWData = dWData;
                end else if (iWants) begin
                    mOwner = 1; mAge = 0; mReq = 1; mWe = 0; mAddr = iAddr;
                end
            end else begin
                mAge++;
                if (memAck || mAge == TO) begin
                    aborted = !memAck;
                    if (aborted) mErr = 1;
                    if (mOwner == 1) begin
                        mIReady = 1;
                        mIData  = aborted ? 32'hFFFF_FFFF : memRData;
                    end else begin
                        mDReady = 1;
                        if (aborted) mDRData = 32'hFFFF_FFFF;
                        else if (!mWe) mDRData = memRData;
                    end
                    mOwner = 0;
                    mReq   = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, plus a run-length monitor of memReq.
    always @(negedge clk) begin
        if (dRead && dWrite) $display("[TB] illegal stimulus: dRead and dWrite both high");
        if (memReq === 1'b1) begin
            reqRun++;
        end else if (reqRun > 0) begin
            lastReqLen = reqRun;
            reqRun     = 0;
        end
        if (checkEn) begin
            checkOutput("memReq",   {31'b0, memReq},    {31'b0, mReq});
            checkOutput("memWe",    {31'b0, memWe},     {31'b0, mWe});
            checkOutput("memAddr",  memAddr,            mAddr);
            checkOutput("memWData", memWData,           mWData);
            checkOutput("iData",    iData,              mIData);
            checkOutput("dRData",   dRData,             mDRData);
            checkOutput("iReady",   {31'b0, iReady},    {31'b0, mIReady});
            checkOutput("dReady",   {31'b0, dReady},    {31'b0, mDReady});
            checkOutput("error",    {31'b0, errorFlag}, {31'b0, mErr});
            checkOutput("stall",    {31'b0, stall},
                        {31'b0, (iReq && !mIReady) || ((dRead || dWrite) && !mDReady)});
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for memReq, records the latched bus fields, acks in request cycle 'delay'.
    task automatic applyStimulus(input int delay, input logic [31:0] rdata,
                                 output logic [31:0] addr, output logic we, output logic [31:0] wdata);
        int n;
        n = 0;
        while (memReq !== 1'b1 && n < 50) begin
            nextCycle();
            n++;
        end
        checkOutput("reqSeen", {31'b0, memReq}, 32'd1);
        addr  = memAddr;
        we    = memWe;
        wdata = memWData;
        repeat (delay - 1) nextCycle();
        memAck   = 1'b1;
        memRData = rdata;
        nextCycle();
        memAck   = 1'b0;
        memRData = 32'hDEAD_BEEF;
    endtask

    logic [31:0] gotAddr, gotWData;
    logic        gotWe;
    int          reqCyc, n;

    initial begin
        reset = 1'b1; iReq = 0; dRead = 0; dWrite = 0; memAck = 0;
        iAddr = '0; dAddr = '0; dWData = '0; memRData = 32'hDEAD_BEEF;
        nextCycle();
        nextCycle();
        checkEn = 1'b1;
        checkOutput("rstMemReq", {31'b0, memReq}, 32'd0);
        checkOutput("rstIData", iData, 32'd0);
        checkOutput("rstError", {31'b0, errorFlag}, 32'd0);
        reset = 1'b0;
        nextCycle();

        // Fetch only, three-cycle request.
        iReq = 1; iAddr = 32'h0000_0040;
        applyStimulus(3, 32'h2008_0005, gotAddr, gotWe, gotWData);
        checkOutput("fetchAddr", gotAddr, 32'h0000_0040);
        checkOutput("fetchWe", {31'b0, gotWe}, 32'd0);
        checkOutput("fetchReady", {31'b0, iReady}, 32'd1);
        checkOutput("fetchData", iData, 32'h2008_0005);
        checkOutput("fetchStall", {31'b0, stall}, 32'd0);
        iReq = 0;
        nextCycle();
        checkOutput("fetchReqLen", lastReqLen, 32'd3);

        // Simultaneous requests: data first, fetch right after.
        iReq = 1; iAddr = 32'h0000_0300; dRead = 1; dAddr = 32'h0000_0100;
        applyStimulus(2, 32'h1111_1111, gotAddr, gotWe, gotWData);
        checkOutput("prioAddr", gotAddr, 32'h0000_0100);
        checkOutput("prioDReady", {31'b0, dReady}, 32'd1);
        checkOutput("prioIReady", {31'b0, iReady}, 32'd0);
        dRead = 0;
        applyStimulus(1, 32'h2222_2222, gotAddr, gotWe, gotWData);
        checkOutput("secondAddr", gotAddr, 32'h0000_0300);
        checkOutput("secondData", iData, 32'h2222_2222);
        checkOutput("secondDRData", dRData, 32'h1111_1111);
        iReq = 0;
        nextCycle();

        // Zero-wait store.
        dWrite = 1; dAddr = 32'h0000_0200; dWData = 32'hCAFE_F00D;
        reqCyc = cyc;
        applyStimulus(1, 32'h3333_3333, gotAddr, gotWe, gotWData);
        checkOutput("storeWe", {31'b0, gotWe}, 32'd1);
        checkOutput("storeWData", gotWData, 32'hCAFE_F00D);
        checkOutput("storeReady", {31'b0, dReady}, 32'd1);
        checkOutput("storeLatency", cyc - reqCyc, 32'd2);
        checkOutput("storeRData", dRData, 32'h1111_1111);
        dWrite = 0;
        nextCycle();

        // Timeout: no ack ever arrives.
        dRead = 1; dAddr = 32'h0000_0400;
        n = 0;
        while (dReady !== 1'b1 && n < 20) begin
            nextCycle();
            n++;
        end
        checkOutput("toReady", {31'b0, dReady}, 32'd1);
        checkOutput("toData", dRData, 32'hFFFF_FFFF);
        checkOutput("toError", {31'b0, errorFlag}, 32'd1);
        dRead = 0;
        nextCycle();
        checkOutput("toReqLen", lastReqLen, 32'd4);
        iReq = 1; iAddr = 32'h0000_0044;
        applyStimulus(2, 32'h4444_4444, gotAddr, gotWe, gotWData);
        iReq = 0;
        checkOutput("stickyError", {31'b0, errorFlag}, 32'd1);
        nextCycle();

        // Reset in the middle of a data read, then a late ack.
        dRead = 1; dAddr = 32'h0000_0500;
        n = 0;
        while (memReq !== 1'b1 && n < 20) begin
            nextCycle();
            n++;
        end
        nextCycle();
        reset = 1; dRead = 0;
        nextCycle();
        checkOutput("midRstReq", {31'b0, memReq}, 32'd0);
        checkOutput("midRstRData", dRData, 32'd0);
        checkOutput("midRstError", {31'b0, errorFlag}, 32'd0);
        reset = 0; memAck = 1; memRData = 32'h5555_5555;
        nextCycle();
        memAck = 0;
        nextCycle();
        checkOutput("lateAckReady", {31'b0, dReady}, 32'd0);
        checkOutput("lateAckReq", {31'b0, memReq}, 32'd0);

        // Spurious ack in IDLE, then a request held through its ready cycle.
        memAck = 1;
        nextCycle();
        memAck = 0;
        checkOutput("spurReq", {31'b0, memReq}, 32'd0);
        iReq = 1; iAddr = 32'h0000_0600;
        applyStimulus(2, 32'h6666_6666, gotAddr, gotWe, gotWData);
        checkOutput("heldReady", {31'b0, iReady}, 32'd1);
        nextCycle();
        checkOutput("noRegrant", {31'b0, memReq}, 32'd0);
        nextCycle();
        checkOutput("regrant", {31'b0, memReq}, 32'd1);
        applyStimulus(1, 32'h7777_7777, gotAddr, gotWe, gotWData);
        iReq = 0;
        checkOutput("regrantData", iData, 32'h7777_7777);
        repeat (3) nextCycle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one external single-ported memory bus between the core's instruction-fetch port and its data (MEM-stage) port. It serialises requests with fixed data-over-fetch priority and drives a variable-latency req/ack handshake to memory. It returns read data and a one-cycle ready pulse to the winning port, and raises a pipeline stall while any port is waiting. It sits between the 5-stage core's `instrAddr`/`memAddr`/`memRead`/`memWrite` signals and the board memory controller.

## Interface
Parameters:
- ADDR_WIDTH, 32: address width, both ports and memory.
- DATA_WIDTH, 32: data width.
- TIMEOUT, 64: maximum cycles `memReq__o` is held without ack before abort. 0 disables the watchdog.

Ports:
- clock__i  in  1  single clock; all state updates on the rising edge.
- reset__i  in  1  synchronous, active-high reset.
- iReq__i  in  1  fetch request, level, held until `iReady__o`.
- iAddr__i  in  ADDR_WIDTH  fetch address.
- iData__o  out  DATA_WIDTH  fetched instruction, registered.
- iReady__o  out  1  one-cycle fetch completion pulse.
- dRead__i  in  1  data read request, level.
- dWrite__i  in  1  data write request, level.
- dAddr__i  in  ADDR_WIDTH  data address.
- dWData__i  in  DATA_WIDTH  store data.
- dRData__o  out  DATA_WIDTH  load data, registered.
- dReady__o  out  1  one-cycle data completion pulse.
- stall__o  out  1  combinational pipeline stall.
- memReq__o  out  1  memory request, registered.
- memWe__o  out  1  1 = write, 0 = read.
- memAddr__o  out  ADDR_WIDTH  memory address.
- memWData__o  out  DATA_WIDTH  memory write data.
- memAck__i  in  1  memory completion. Read data is valid in the same cycle.
- memRData__i  in  DATA_WIDTH  memory read data.
- error__o  out  1  sticky timeout flag.

## Operation
- FSM states:
  - IDLE
  - IBUSY: fetch transaction outstanding.
  - DBUSY: data transaction outstanding.
- IDLE arbitration:
  - A port is *pending* if its request is high and its ready output is low in that cycle. A ready-pulse cycle never re-grants the same port.
  - Data pending → DBUSY. Otherwise fetch pending → IBUSY. Data always wins a simultaneous request.
- On grant, latch `memAddr__o`, `memWe__o` (= `dWrite__i`; 0 for fetch) and `memWData__o` (`dWData__i` for writes, else unchanged). Set `memReq__o` = 1.
- In BUSY, all `mem*` outputs are held constant until `memAck__i` is sampled high. Then:
  - `memReq__o` → 0 and state → IDLE.
  - The granted port's ready pulses for exactly one cycle.
  - On reads, `memRData__i` is loaded into `iData__o` or `dRData__o`. On writes, `dRData__o` is unchanged.
- `iData__o` and `dRData__o` hold their value until the next completion on the same port.
- `dRead__i` and `dWrite__i` both high: treated as a write. This is illegal stimulus; the bench flags it.
- Dropping a request before its ready pulse is illegal. The transaction completes anyway.
- `memAck__i` while IDLE is ignored.
- `stall__o` = (`iReq__i` & ~`iReady__o`) | ((`dRead__i` | `dWrite__i`) & ~`dReady__o`).
- Watchdog (TIMEOUT > 0):
  - A counter of width $clog2(TIMEOUT+1) clears on grant and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT, abort: `memReq__o` → 0, ready pulse, read data register loaded with all-ones, `error__o` ← 1 (sticky until reset).
  - Ack in the same cycle as the timeout: ack wins and no error is flagged.
- Reset: state IDLE; all outputs 0 (`memReq__o`, `memWe__o`, `memAddr__o`, `memWData__o`, `iData__o`, `dRData__o`, both readys, `error__o`); counter 0.
- Reset mid-transaction abandons it: `memReq__o` is low the cycle after reset and no ready pulse is issued.

## Timing
- Request seen pending in IDLE in cycle c → `memReq__o` high in cycle c+1.
- `memAck__i` high in cycle a → ready pulse, valid data and `memReq__o` low all in cycle a+1.
- Zero-wait memory (ack in the first req cycle): request at c → ready at c+2.
- Back-to-back: the other port, if pending in cycle a+1, is granted then and `memReq__o` rises in a+2. Minimum one low cycle of `memReq__o` between transactions.
- Timeout: `memReq__o` stays high for exactly TIMEOUT cycles, then ready and `error__o` assert the next cycle.

## Test plan
- Fetch only, `iAddr__i`=0x0000_0040, ack 3 cycles after req with `memRData__i`=0x2008_0005 → `memReq__o` high 3 cycles, `memWe__o`=0; `iReady__o` pulses once; `iData__o`=0x2008_0005; `stall__o` low in the ready cycle.
- Simultaneous `iReq__i` and `dRead__i`, `dAddr__i`=0x100 → data granted first (`memAddr__o`=0x100). After `dReady__o`, fetch granted the next cycle. Two ready pulses, never overlapping.
- Store `dWrite__i`, `dAddr__i`=0x200, `dWData__i`=0xCAFE_F00D, zero-wait ack → `memWe__o`=1, `memWData__o`=0xCAFE_F00D, `dReady__o` two cycles after the request, `dRData__o` unchanged.
- TIMEOUT=4, ack never arrives → `memReq__o` high exactly 4 cycles; then `dRData__o`=0xFFFF_FFFF, `dReady__o` pulse and `error__o`=1, remaining 1 after later good transactions until reset.
- `reset__i` asserted mid-DBUSY, then a late `memAck__i` → no ready pulse; all outputs 0 the cycle after reset; stray ack ignored.
- Spurious `memAck__i` in IDLE, plus a request held through its ready cycle → no transaction from the ack; the held request is re-granted only from the cycle after ready.
